// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - writeback request, issue and register-file write bundle
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic [4:0]        chk_rs;
  logic [4:0]        chk_rs2;
  logic              stall;
  logic [4:0]        wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              reg_wr;
  logic              r_type;
  logic [31:0]       busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output iss_valid, iss_rd, chk_rs, chk_rs2,
    input  alu_ready, mem_ready, stall, wr_rd, wr_data, reg_wr, r_type, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  iss_valid, iss_rd, chk_rs, chk_rs2,
    output alu_ready, mem_ready, stall, wr_rd, wr_data, reg_wr, r_type, busy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - round-robin ALU/load writeback arbiter with RAW scoreboard
module regfile_wb_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  regfile_wb_ctrl_if.slave bus
);
  logic              r_prio_mem;
  logic [31:0]       r_busy;
  logic              r_reg_wr;
  logic [4:0]        r_wr_rd;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_alu_gnt;
  logic              w_mem_gnt;
  logic              w_gnt;
  logic [4:0]        w_gnt_rd;
  logic [DATA_W-1:0] w_gnt_data;
  logic [31:0]       w_busy_nxt;

  // Contention is settled by the pointer; a lone requester always wins.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_mem_gnt = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && bus.mem_valid) begin
        w_mem_gnt = r_prio_mem;
        w_alu_gnt = !r_prio_mem;
      end else begin
        w_alu_gnt = bus.alu_valid;
        w_mem_gnt = bus.mem_valid;
      end
    end
  end

  assign w_gnt      = w_alu_gnt | w_mem_gnt;
  assign w_gnt_rd   = w_mem_gnt ? bus.mem_rd   : bus.alu_rd;
  assign w_gnt_data = w_mem_gnt ? bus.mem_data : bus.alu_data;

  // Set is applied after clear so a same-index issue keeps the bit busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt && (w_gnt_rd != 5'd0)) begin
      w_busy_nxt[w_gnt_rd] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      w_busy_nxt[bus.iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_mem <= 1'b1;
      r_busy     <= '0;
      r_reg_wr   <= 1'b0;
      r_wr_rd    <= '0;
      r_wr_data  <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_reg_wr <= w_gnt && (w_gnt_rd != 5'd0);
      if (w_gnt) begin
        r_wr_rd    <= w_gnt_rd;
        r_wr_data  <= w_gnt_data;
        r_prio_mem <= w_alu_gnt;
      end
    end
  end

  assign bus.alu_ready = w_alu_gnt;
  assign bus.mem_ready = w_mem_gnt;
  assign bus.stall     = !reset && (r_busy[bus.chk_rs] || r_busy[bus.chk_rs2]);
  assign bus.wr_rd     = r_wr_rd;
  assign bus.wr_data   = r_wr_data;
  assign bus.reg_wr    = r_reg_wr;
  assign bus.r_type    = 1'b1;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - scoreboard bench with randomized traffic and reference model
module tb_regfile_wb_ctrl;
  logic clk;
  logic reset;

  regfile_wb_ctrl_if #(.DATA_W(32)) bus ();

  regfile_wb_ctrl #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM} src_e;

  typedef struct {
    bit          wr;
    bit          chk;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 0;

  // Reference model state
  src_e        m_last   = SRC_ALU;
  bit          m_busy[32];
  logic [4:0]  m_wr_rd  = '0;
  logic [31:0] m_wr_data = '0;
  bit          m_known  = 0;
  src_e        g_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, predict, cross the edge.
  task automatic cyc(input bit rst,
                     input bit av, input logic [4:0] ard, input logic [31:0] adata,
                     input bit mv, input logic [4:0] mrd, input logic [31:0] mdata,
                     input bit iv, input logic [4:0] ird,
                     input logic [4:0] c1, input logic [4:0] c2);
    src_e        g;
    exp_t        e;
    logic [4:0]  grd;
    logic [31:0] gdata;
    logic [31:0] bvec;
    reset         = rst;
    bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = adata;
    bus.mem_valid = mv;  bus.mem_rd = mrd; bus.mem_data = mdata;
    bus.iss_valid = iv;  bus.iss_rd = ird;
    bus.chk_rs    = c1;  bus.chk_rs2 = c2;
    #1;
    if (rst)            g = SRC_NONE;
    else if (av && mv)  g = (m_last == SRC_MEM) ? SRC_ALU : SRC_MEM;
    else if (av)        g = SRC_ALU;
    else if (mv)        g = SRC_MEM;
    else                g = SRC_NONE;
    g_now = g;
    check("alu_ready", 64'(bus.alu_ready), 64'(g == SRC_ALU));
    check("mem_ready", 64'(bus.mem_ready), 64'(g == SRC_MEM));
    check("ready_onehot", 64'(bus.alu_ready && bus.mem_ready), 64'd0);
    check("stall", 64'(bus.stall), 64'(!rst && (m_busy[c1] || m_busy[c2])));

    grd   = (g == SRC_MEM) ? mrd : ard;
    gdata = (g == SRC_MEM) ? mdata : adata;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_last = SRC_ALU;
      m_wr_rd = '0; m_wr_data = '0; m_known = 1;
      e.wr = 0;
    end else begin
      e.wr = (g != SRC_NONE) && (grd != 0);
      if (g != SRC_NONE) begin
        m_last = g;
        if (grd != 0) begin
          m_busy[grd] = 0;
          m_wr_rd = grd; m_wr_data = gdata; m_known = 1;
        end else begin
          m_known = 0;
        end
      end
      if (iv && ird != 0) m_busy[ird] = 1;
    end
    e.chk = m_known; e.rd = m_wr_rd; e.data = m_wr_data;
    exp_q.push_back(e);
    started = 1;

    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) bvec[i] = m_busy[i];
    check("busy", 64'(bus.busy), 64'(bvec));
    check("r_type", 64'(bus.r_type), 64'd1);
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per edge and compares the registered write port.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underrun", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("reg_wr", 64'(bus.reg_wr), 64'(e.wr));
          if (e.chk) begin
            check("wr_rd", 64'(bus.wr_rd), 64'(e.rd));
            check("wr_data", 64'(bus.wr_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a_pend, m_pend, av, mv;
    logic [4:0]  ard, mrd;
    logic [31:0] adata, mdata;
    int          a_wait, m_wait;

    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.chk_rs = 0; bus.chk_rs2 = 0;
    @(negedge clk);

    idle(1); idle(1);
    check("rst_wr_rd", 64'(bus.wr_rd), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Contention straight after reset: mem first, then alu
    cyc(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    check("rr_first_rd", 64'(bus.wr_rd), 64'd4);
    check("rr_first_data", 64'(bus.wr_data), 64'h22);
    check("rr_first_wr", 64'(bus.reg_wr), 64'd1);
    cyc(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    check("rr_second_rd", 64'(bus.wr_rd), 64'd3);
    check("rr_second_data", 64'(bus.wr_data), 64'h11);
    idle(0);

    // RAW hazard on r7 released by its writeback
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    check("raw_stall_hold", 64'(bus.stall), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    cyc(0, 1, 7, 32'hA5A5, 0, 0, 0, 0, 0, 7, 0);
    check("raw_busy7_clear", 64'(bus.busy[7]), 64'd0);
    check("raw_stall_released", 64'(bus.stall), 64'd0);
    idle(0);

    // Same-edge set and clear on r5: set wins
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 32'h55, 1, 5, 0, 0);
    check("set_wins_busy5", 64'(bus.busy[5]), 64'd1);
    cyc(0, 1, 5, 32'h66, 0, 0, 0, 1, 6, 5, 6);

    // Write to r0 is accepted but never lands
    cyc(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    check("r0_no_write", 64'(bus.reg_wr), 64'd0);

    // Reset cancels a pending mem grant
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cyc(1, 0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
    check("rst_grant_dropped", 64'(bus.reg_wr), 64'd0);
    check("rst_busy_cleared", 64'(bus.busy), 64'd0);

    // Random traffic with hold-while-waiting requesters
    a_pend = 0; m_pend = 0; a_wait = 0; m_wait = 0;
    ard = 0; mrd = 0; adata = 0; mdata = 0;
    for (int n = 0; n < 1000; n++) begin
      if (!a_pend) begin
        av = ($urandom_range(0, 3) != 0);
        ard = 5'($urandom_range(0, 31));
        adata = $urandom;
      end else av = 1;
      if (!m_pend) begin
        mv = ($urandom_range(0, 3) != 0);
        mrd = 5'($urandom_range(0, 31));
        mdata = $urandom;
      end else mv = 1;
      cyc(0, av, ard, adata, mv, mrd, mdata,
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      a_pend = av && (g_now != SRC_ALU);
      m_pend = mv && (g_now != SRC_MEM);
      a_wait = (a_pend && mv) ? a_wait + 1 : 0;
      m_wait = (m_pend && av) ? m_wait + 1 : 0;
      if (a_wait > 1 || m_wait > 1) begin
        check("starvation", 64'(a_wait > m_wait ? a_wait : m_wait), 64'd1);
        a_wait = 0; m_wait = 0;
      end
    end
    idle(0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter: DATA_W, default 32, write-data width; must match the register file busW width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_rd  input  5  ALU destination register index.
REQ-007 alu_data  input  DATA_W  ALU result.
REQ-008 alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-009 mem_valid  input  1  load writeback request.
REQ-010 mem_rd  input  5  load destination register index.
REQ-011 mem_data  input  DATA_W  load data.
REQ-012 mem_ready  output  1  load request granted this cycle (combinational).
REQ-013 iss_valid  input  1  issue stage marks a destination as pending.
REQ-014 iss_rd  input  5  destination register index being issued.
REQ-015 chk_rs, chk_rs2  input  5 each  source indices to hazard-check.
REQ-016 stall  output  1  RAW hazard on chk_rs or chk_rs2 (combinational).
REQ-017 wr_rd  output  5  register-file write index (registered).
REQ-018 wr_data  output  DATA_W  register-file busW (registered).
REQ-019 reg_wr  output  1  register-file write enable (registered).
REQ-020 r_type  output  1  constant 1, so the register file always writes through rd.
REQ-021 busy  output  32  scoreboard bit vector; bit 0 is constant 0.

Function
REQ-022 A request is transferred when valid and ready are both high on a rising clk edge.
- Requesters SHALL hold rd and data stable while valid is high and ready is low.
REQ-023 At most one of alu_ready and mem_ready SHALL be high in any cycle.
- ready is asserted only when the matching valid is high.
REQ-024 If only one requester is valid, that requester SHALL be granted.
REQ-025 If both are valid, the grant SHALL go to the requester not granted most recently (round-robin).
- The priority pointer updates only on a grant.
- After reset the pointer favours mem.
REQ-026 Write latency SHALL be one cycle: a grant at edge N drives wr_rd, wr_data and reg_wr from edge N onward for exactly one cycle.
REQ-027 With no grant at an edge, reg_wr SHALL be 0 after that edge; wr_rd and wr_data hold their previous values.
REQ-028 A granted request with rd = 0 SHALL be accepted (ready high).
- It produces reg_wr = 0 and has no scoreboard effect.
REQ-029 Scoreboard set: when iss_valid = 1 and iss_rd != 0 at an edge, busy[iss_rd] SHALL be 1 after that edge.
REQ-030 Scoreboard clear: when a grant with rd != 0 occurs at an edge, busy[rd] SHALL be 0 after that edge.
- The clear is taken at grant time, so it is visible in the same cycle that reg_wr is asserted.
REQ-031 If a set and a clear target the same index at the same edge, the set SHALL win.
- Setting and clearing different indices at one edge SHALL both take effect.
REQ-032 stall SHALL equal busy[chk_rs] OR busy[chk_rs2].
- Index 0 never contributes.
REQ-033 The block SHALL NOT forward or bypass data; a producer and its consumer are ordered by stall alone.
REQ-034 Issuing to an index that is already busy SHALL leave it busy (single bit, no count).
- Upstream guarantees at most one outstanding producer per index.

Reset
REQ-035 On reset at an edge, all of the following SHALL hold after that edge, with every request ignored at that edge:
- reg_wr = 0, wr_rd = 0, wr_data = 0;
- busy = 0;
- round-robin pointer favours mem.
REQ-036 While reset is high, alu_ready, mem_ready and stall SHALL be 0.
REQ-037 Reset asserted with a grant pending SHALL discard that grant: no write and no scoreboard change.

Verification
REQ-038 Reset, then both valid at once (alu_rd = 3, alu_data = 0x11; mem_rd = 4, mem_data = 0x22) for 2 cycles:
- mem granted first: next cycle wr_rd = 4, wr_data = 0x22, reg_wr = 1;
- alu granted second: following cycle wr_rd = 3, wr_data = 0x11.
REQ-039 Issue iss_rd = 7, then chk_rs = 7:
- stall = 1 until the cycle in which a grant with rd = 7 occurs;
- busy[7] = 0 and stall = 0 from the next edge.
REQ-040 At the same edge, issue iss_rd = 5 and grant a write to rd = 5 -> busy[5] remains 1.
REQ-041 alu_valid with alu_rd = 0, alu_data = 0xFFFFFFFF -> alu_ready = 1, reg_wr stays 0, busy unchanged.
REQ-042 Assert reset in the cycle of a mem grant (mem_rd = 9, busy[9] = 1) -> reg_wr = 0 and busy = 0 after that edge.
REQ-043 Random valid traffic on both ports for 1000 cycles. Check that:
- the two readys are never both high;
- no valid request waits more than 1 cycle while the other port is also continuously valid.
